// File: rtl/sop_share_eval_pipe.sv
// -----------------------------------------------------------------------------
// sop_share_eval_pipe
//   Runtime-configurable shared-logic sum-of-products evaluator. N_PROD product
//   terms over N_IN inputs are shared by N_OUT OR-outputs through a loadable
//   selection matrix. Configuration is double buffered: writes land in a shadow
//   copy and are swapped into the active copy only after the pipeline drains.
//   An on-line monitor compares every result with the exact sum lo + hi of the
//   operand and keeps a saturating violation count and the largest error seen.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cfg_wr          write one shadow entry (ignored while cfg_busy)
//   cfg_sel         0: product entry, 1: output entry
//   cfg_idx         entry index (out-of-range writes are dropped)
//   cfg_data        entry payload, LSB aligned
//   cfg_commit      request shadow->active swap (pulse)
//   cfg_busy        swap pending
//   in_valid/in_ready/in_data     operand stream {hi, lo}
//   out_valid/out_ready           result stream
//   out_data        approximate result
//   out_exact       exact sum for the same operand
//   out_viol        |out_data - out_exact| > ET
//   err_cnt         saturating count of violating results
//   max_err         largest |approx - exact| over delivered results
//   dbg_state       current FSM state (0 RUN, 1 DRAIN, 2 SWAP)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holds data stable while valid & !ready; ready never depends
// on the same interface's valid.
// -----------------------------------------------------------------------------
module sop_share_eval_pipe #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int N_PROD = 3,
    parameter int ET     = 4,
    parameter int CNT_W  = 16,
    localparam int IDX_N = (N_PROD > N_OUT) ? N_PROD : N_OUT,
    localparam int IDX_W = (IDX_N > 1) ? $clog2(IDX_N) : 1,
    localparam int D_W   = (2 * N_IN > N_PROD + 1) ? 2 * N_IN : N_PROD + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic             cfg_sel,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [D_W-1:0]   cfg_data,
    input  logic             cfg_commit,
    output logic             cfg_busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    output logic [N_OUT-1:0] out_exact,
    output logic             out_viol,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N_OUT-1:0] max_err,
    output logic [1:0]       dbg_state
);

    localparam int HALF = N_IN / 2;
    localparam logic [31:0] ET_U = 32'(ET);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t state, state_next;

    // Configuration: product entry = {pol_i, use_i} pairs, output entry = {en, sel}.
    logic [2*N_IN-1:0] sh_prod  [N_PROD];
    logic [2*N_IN-1:0] act_prod [N_PROD];
    logic [N_PROD:0]   sh_out   [N_OUT];
    logic [N_PROD:0]   act_out  [N_OUT];

    // Pipeline registers
    logic              s1_valid;
    logic [N_PROD-1:0] s1_prod;
    logic [N_OUT-1:0]  s1_exact;
    logic [N_OUT-1:0]  out_diff;

    logic              s1_load, s2_load, out_fire;
    logic [N_PROD-1:0] prod_now;
    logic [N_OUT-1:0]  exact_now;
    logic [N_OUT-1:0]  approx_now;
    logic [N_OUT-1:0]  diff_now;
    logic              viol_now;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cfg_busy   = 1'b1;
        case (state)
            ST_RUN: begin
                cfg_busy = 1'b0;
                if (cfg_commit) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Swap only once nothing evaluated under the old config remains.
                if (!s1_valid && !out_valid) state_next = ST_SWAP;
            end
            ST_SWAP: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign dbg_state = state;

    // ---------------------------------------------------------------- config
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < N_PROD; p++) begin
                sh_prod[p]  <= '0;
                act_prod[p] <= '0;
            end
            for (int o = 0; o < N_OUT; o++) begin
                sh_out[o]  <= '0;
                act_out[o] <= '0;
            end
        end else begin
            if (cfg_wr && !cfg_busy) begin
                // Matching against each legal index drops out-of-range writes.
                for (int p = 0; p < N_PROD; p++) begin
                    if (!cfg_sel && cfg_idx == IDX_W'(p)) sh_prod[p] <= cfg_data[2*N_IN-1:0];
                end
                for (int o = 0; o < N_OUT; o++) begin
                    if (cfg_sel && cfg_idx == IDX_W'(o)) sh_out[o] <= cfg_data[N_PROD:0];
                end
            end
            if (state == ST_SWAP) begin
                for (int p = 0; p < N_PROD; p++) act_prod[p] <= sh_prod[p];
                for (int o = 0; o < N_OUT; o++) act_out[o] <= sh_out[o];
            end
        end
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        for (int p = 0; p < N_PROD; p++) begin
            prod_now[p] = 1'b1;
            for (int i = 0; i < N_IN; i++) begin
                // A used literal fails when the input differs from its polarity.
                if (act_prod[p][2*i] && (in_data[i] != act_prod[p][2*i+1])) prod_now[p] = 1'b0;
            end
        end
        exact_now = N_OUT'(in_data[HALF-1:0]) + N_OUT'(in_data[N_IN-1:HALF]);
    end

    always_comb begin
        for (int o = 0; o < N_OUT; o++) begin
            approx_now[o] = act_out[o][N_PROD] & (|(act_out[o][N_PROD-1:0] & s1_prod));
        end
        diff_now = (approx_now >= s1_exact) ? (approx_now - s1_exact) : (s1_exact - approx_now);
        viol_now = {{(32-N_OUT){1'b0}}, diff_now} > ET_U;
    end

    assign out_fire = out_valid & out_ready;
    assign s2_load  = s1_valid & (!out_valid | out_ready);
    assign in_ready = (state == ST_RUN) & (!s1_valid | s2_load);
    assign s1_load  = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_exact  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_exact <= '0;
            out_diff  <= '0;
            out_viol  <= 1'b0;
        end else begin
            s1_valid  <= s1_load | (s1_valid & !s2_load);
            out_valid <= s2_load | (out_valid & !out_ready);
            if (s1_load) begin
                s1_prod  <= prod_now;
                s1_exact <= exact_now;
            end
            if (s2_load) begin
                out_data  <= approx_now;
                out_exact <= s1_exact;
                out_diff  <= diff_now;
                out_viol  <= viol_now;
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    // Updates only on the handshake, so a stalled result is counted once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            max_err <= '0;
        end else if (out_fire) begin
            if (out_viol && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            if (out_diff > max_err) max_err <= out_diff;
        end
    end

endmodule

// File: tb/tb_sop_share_eval_pipe.sv
module tb_sop_share_eval_pipe;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 3;
  localparam int N_PROD = 3;
  localparam int ET     = 4;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 2;
  localparam int D_W    = 8;
  localparam int EXP_W  = 2 * N_OUT + 1;

  logic             clk;
  logic             rst;
  logic             cfg_wr;
  logic             cfg_sel;
  logic [IDX_W-1:0] cfg_idx;
  logic [D_W-1:0]   cfg_data;
  logic             cfg_commit;
  logic             cfg_busy;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_data;
  logic [N_OUT-1:0] out_exact;
  logic             out_viol;
  logic [CNT_W-1:0] err_cnt;
  logic [N_OUT-1:0] max_err;
  logic [1:0]       dbg_state;

  sop_share_eval_pipe #(
    .N_IN(N_IN), .N_OUT(N_OUT), .N_PROD(N_PROD), .ET(ET), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exact(out_exact), .out_viol(out_viol),
    .err_cnt(err_cnt), .max_err(max_err), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard state
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [2*N_IN-1:0] m_sh_prod  [N_PROD];
  logic [N_PROD:0]   m_sh_out   [N_OUT];
  logic [2*N_IN-1:0] m_act_prod [N_PROD];
  logic [N_PROD:0]   m_act_out  [N_OUT];

  logic [EXP_W-1:0] exp_q[$];
  int out_cyc[$];
  int m_err = 0;
  int m_max = 0;
  bit stall_pending = 0;
  logic [EXP_W-1:0] stall_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: each product is true when every literal it uses matches the
  // operand; each output is its enable ANDed with "any selected product true".
  function automatic logic [EXP_W-1:0] model_eval(input logic [N_IN-1:0] d);
    int lo, hi, exact, approx, diff;
    bit prod_true [N_PROD];
    lo = int'(d) % (1 << (N_IN / 2));
    hi = int'(d) / (1 << (N_IN / 2));
    exact = lo + hi;
    for (int p = 0; p < N_PROD; p++) begin
      int used, matched;
      used = 0;
      matched = 0;
      for (int i = 0; i < N_IN; i++) begin
        if (m_act_prod[p][2*i]) begin
          used++;
          if (d[i] == m_act_prod[p][2*i+1]) matched++;
        end
      end
      prod_true[p] = (used == matched);
    end
    approx = 0;
    for (int o = 0; o < N_OUT; o++) begin
      bit any;
      any = 0;
      for (int p = 0; p < N_PROD; p++) if (m_act_out[o][p] && prod_true[p]) any = 1;
      if (m_act_out[o][N_PROD] && any) approx += (1 << o);
    end
    diff = (approx > exact) ? approx - exact : exact - approx;
    return {N_OUT'(approx), N_OUT'(exact), (diff > ET)};
  endfunction

  // Observes the interfaces mid-cycle; every handshake seen here completes on
  // the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_err = 0;
      m_max = 0;
      stall_pending = 0;
      for (int p = 0; p < N_PROD; p++) m_act_prod[p] = '0;
      for (int o = 0; o < N_OUT; o++) m_act_out[o] = '0;
    end else begin
      check("err_cnt", 32'(err_cnt), 32'(m_err));
      check("max_err", 32'(max_err), 32'(m_max));
      if (stall_pending) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'({out_data, out_exact, out_viol}), 32'(stall_word));
      end
      stall_pending = out_valid && !out_ready;
      stall_word = {out_data, out_exact, out_viol};
      if (in_valid && in_ready) exp_q.push_back(model_eval(in_data));
      if (cfg_commit) begin
        for (int p = 0; p < N_PROD; p++) m_act_prod[p] = m_sh_prod[p];
        for (int o = 0; o < N_OUT; o++) m_act_out[o] = m_sh_out[o];
      end
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          logic [EXP_W-1:0] e;
          int a, x, df;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[EXP_W-1 -: N_OUT]));
          check("out_exact", 32'(out_exact), 32'(e[N_OUT:1]));
          check("out_viol", 32'(out_viol), 32'(e[0]));
          a = int'(e[EXP_W-1 -: N_OUT]);
          x = int'(e[N_OUT:1]);
          df = (a > x) ? a - x : x - a;
          if (e[0] && m_err != (1 << CNT_W) - 1) m_err++;
          if (df > m_max) m_max = df;
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic model_write(input logic sel, input logic [IDX_W-1:0] idx, input logic [D_W-1:0] d);
    if (!sel && int'(idx) < N_PROD) m_sh_prod[idx] = d[2*N_IN-1:0];
    if (sel && int'(idx) < N_OUT) m_sh_out[idx] = d[N_PROD:0];
  endtask

  task automatic cfg_write(input logic sel, input logic [IDX_W-1:0] idx, input logic [D_W-1:0] d);
    cfg_wr = 1'b1;
    cfg_sel = sel;
    cfg_idx = idx;
    cfg_data = d;
    model_write(sel, idx, d);
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cfg_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (cfg_busy) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [N_IN-1:0] d, input bit hold, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic clear_shadow_model();
    for (int p = 0; p < N_PROD; p++) m_sh_prod[p] = '0;
    for (int o = 0; o < N_OUT; o++) m_sh_out[o] = '0;
  endtask

  task automatic drain(input string tag);
    repeat (6) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 32'd0);
  endtask

  // ---------------------------------------------------------------- test sequence
  initial begin
    int w;
    rst = 1'b1;
    cfg_wr = 0; cfg_sel = 0; cfg_idx = '0; cfg_data = '0; cfg_commit = 0;
    in_valid = 0; in_data = '0; out_ready = 1'b1;
    clear_shadow_model();
    #23 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_exact", 32'(out_exact), 32'd0);
    check("rst_out_viol", 32'(out_viol), 32'd0);
    check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;

    // 1: zero config, 0xF -> out 0, exact 6, violation
    send(4'hF, 0, w);
    @(negedge clk);
    check("t1_lat1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'd0);
    check("t1_exact", 32'(out_exact), 32'd6);
    check("t1_viol", 32'(out_viol), 32'd1);
    @(posedge clk); #1;
    check("t1_err_cnt", 32'(err_cnt), 32'd1);
    check("t1_max_err", 32'(max_err), 32'd6);

    // 4: back-pressure, three operands under a 5-cycle stall
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'hF;
    @(negedge clk); check("t4_ready0", 32'(in_ready), 32'd1);
    @(posedge clk); #1; in_data = 4'hE;
    @(negedge clk); check("t4_ready1", 32'(in_ready), 32'd1);
    @(posedge clk); #1; in_data = 4'hB;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("t4_ready_full", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); check("t4_ready_resume", 32'(in_ready), 32'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    drain("t4_drain");
    check("t4_err_cnt", 32'(err_cnt), 32'd4);
    check("t4_max_err", 32'(max_err), 32'd6);

    // 2: p0 constant-1, o0/o1 select p0, o2 disabled
    cfg_write(0, 2'd0, 8'h00);
    cfg_write(1, 2'd0, 8'h09);
    cfg_write(1, 2'd1, 8'h09);
    cfg_write(1, 2'd2, 8'h00);
    cfg_write(0, 2'd3, 8'hFF);
    cfg_write(1, 2'd3, 8'h0F);
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    check("t2_busy_drain", 32'(cfg_busy), 32'd1);
    check("t2_state_drain", 32'(dbg_state), 32'd1);
    check("t2_in_ready_busy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("t2_state_swap", 32'(dbg_state), 32'd2);
    @(posedge clk); #1;
    check("t2_busy_done", 32'(cfg_busy), 32'd0);
    send(4'h5, 0, w);
    @(negedge clk);
    check("t2_lat1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_data", 32'(out_data), 32'b011);
    check("t2_exact", 32'(out_exact), 32'b010);
    check("t2_viol", 32'(out_viol), 32'd0);
    @(posedge clk); #1;
    drain("t2_drain");

    // 3: eight back-to-back operands
    for (int k = 0; k < 8; k++) begin
      send(N_IN'($urandom_range(0, 15)), (k < 7), w);
      check("t3_no_wait", 32'(w), 32'd0);
    end
    drain("t3_drain");
    for (int j = out_cyc.size() - 7; j < out_cyc.size(); j++)
      check("t3_consecutive", 32'(out_cyc[j] - out_cyc[j-1]), 32'd1);

    // 5: commit with two operands in flight; a write while busy is dropped
    cfg_write(0, 2'd1, 8'h03);
    cfg_write(1, 2'd2, 8'h0A);
    send(4'h1, 1, w);
    send(4'h1, 0, w);
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    check("t5_busy", 32'(cfg_busy), 32'd1);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    cfg_wr = 1'b1; cfg_sel = 1'b1; cfg_idx = 2'd0; cfg_data = 8'h00;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    in_valid = 1'b1;
    in_data = 4'h1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      check("t5_busy_blocks", 32'(cfg_busy), 32'd1);
      @(negedge clk);
      w++;
    end
    check("t5_accepted", 32'(in_ready), 32'd1);
    check("t5_not_busy", 32'(cfg_busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("t5_drain");

    // Random traffic with random config updates and back-pressure
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = N_IN'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_wr = 1'b0;
      cfg_commit = 1'b0;
      if (!cfg_busy) begin
        if ($urandom_range(0, 5) == 0) begin
          cfg_wr = 1'b1;
          cfg_sel = 1'($urandom_range(0, 1));
          cfg_idx = IDX_W'($urandom_range(0, 3));
          cfg_data = D_W'($urandom_range(0, 255));
          model_write(cfg_sel, cfg_idx, cfg_data);
        end
        if ($urandom_range(0, 24) == 0) cfg_commit = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cfg_wr = 1'b0;
    cfg_commit = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    drain("rand_drain");

    // 6: asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = N_IN'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_err_cnt", 32'(err_cnt), 32'd0);
    check("t6_max_err", 32'(max_err), 32'd0);
    check("t6_busy", 32'(cfg_busy), 32'd0);
    clear_shadow_model();
    @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    send(4'hF, 0, w);
    drain("t6_drain");
    check("t6_err_after", 32'(err_cnt), 32'd1);
    check("t6_max_after", 32'(max_err), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
